serial_sub_nbit: RTL and testbench

- Bit-serial ripple-borrow subtractor; sequential counterpart of the team's combinational ripple-carry adder.
- Computes Diff = in1 - in2 - Bin over WIDTH clock cycles, one bit per cycle, LSB first.
- A single full-subtractor cell plus a borrow flip-flop replaces the N-cell chain, for area-constrained datapaths.
- Controlled by a start/busy/done handshake.

---
 rtl/serial_sub_nbit.sv | 100 ++++++++++
 tb/tb_serial_sub_nbit.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/serial_sub_nbit.sv
// Bit-serial ripple-borrow subtractor: Diff = in1 - in2 - Bin, one bit per clock, LSB first.
// A single full-subtractor cell plus a borrow flip-flop, sequenced by a start/busy/done FSM.
module serial_sub_nbit #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             Bin,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             Vout,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic             borrow_q;
    logic [CW-1:0]    cnt_q;
    logic             a_msb_q;
    logic             b_msb_q;

    logic             d;
    logic             borrow_d;
    logic [WIDTH-1:0] res_d;

    // Full-subtractor cell on the current LSBs.
    always_comb begin
        d        = a_q[0] ^ b_q[0] ^ borrow_q;
        borrow_d = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & borrow_q);
        res_d    = {d, res_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            Diff     <= '0;
            Bout     <= 1'b0;
            Vout     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle, StDone: begin
                    // DONE reloads directly so back-to-back operations have no idle bubble.
                    if (start) begin
                        a_q      <= in1;
                        b_q      <= in2;
                        res_q    <= '0;
                        borrow_q <= Bin;
                        cnt_q    <= '0;
                        a_msb_q  <= in1[WIDTH-1];
                        b_msb_q  <= in2[WIDTH-1];
                        busy     <= 1'b1;
                        state_q  <= StRun;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StRun: begin
                    a_q      <= a_q >> 1;
                    b_q      <= b_q >> 1;
                    res_q    <= res_d;
                    borrow_q <= borrow_d;
                    cnt_q    <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        // Results are published only here; they hold through IDLE and the next RUN.
                        Diff    <= res_d;
                        Bout    <= borrow_d;
                        Vout    <= (a_msb_q != b_msb_q) && (d != a_msb_q);
                        cnt_q   <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= StDone;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub_nbit.sv
// Directed and exhaustive bench for serial_sub_nbit at WIDTH=4.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_serial_sub_nbit;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic         Bin;
    logic [W-1:0] Diff;
    logic         Bout;
    logic         Vout;
    logic         busy;
    logic         done;

    int vectors     = 0;
    int miscompares = 0;

    serial_sub_nbit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .in1   (in1),
        .in2   (in2),
        .Bin   (Bin),
        .Diff  (Diff),
        .Bout  (Bout),
        .Vout  (Vout),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start one operation from IDLE/DONE and check busy for cycles 1..W and the done cycle W+1.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                         input logic [W-1:0] exp_d, input logic exp_b, input logic exp_v,
                         input string tag);
        @(negedge clk);
        in1 = a; in2 = b; Bin = bi; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i <= int'(W); i++) begin
            check({tag, " busy"}, 32'(busy), 32'd1);
            check({tag, " done early"}, 32'(done), 32'd0);
            @(negedge clk);
        end
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " busy end"}, 32'(busy), 32'd0);
        check({tag, " Diff"}, 32'(Diff), 32'(exp_d));
        check({tag, " Bout"}, 32'(Bout), 32'(exp_b));
        check({tag, " Vout"}, 32'(Vout), 32'(exp_v));
    endtask

    initial begin
        logic [W-1:0] md;
        logic         mb;
        logic         mv;
        int           sd;
        int           ud;

        rst = 1'b1; start = 1'b0; in1 = '0; in2 = '0; Bin = 1'b0;
        #12;
        check("reset Diff", 32'(Diff), 32'd0);
        check("reset Bout", 32'(Bout), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // 9-3: signed -7-3 = -10 overflows 4 bits.
        do_op(4'd9, 4'd3, 1'b0, 4'd6, 1'b0, 1'b1, "9-3");
        @(negedge clk);
        check("hold idle Diff", 32'(Diff), 32'd6);
        check("idle done", 32'(done), 32'd0);
        // 3-9: signed 3-(-7) = 10 overflows.
        do_op(4'd3, 4'd9, 1'b0, 4'hA, 1'b1, 1'b1, "3-9");
        do_op(4'd0, 4'd0, 1'b1, 4'hF, 1'b1, 1'b0, "0-0-1");
        do_op(4'd8, 4'd1, 1'b0, 4'd7, 1'b0, 1'b1, "8-1");

        // Second start during RUN must be ignored.
        @(negedge clk);
        in1 = 4'd5; in2 = 4'd2; Bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        in1 = 4'd0; in2 = 4'd1; start = 1'b1;
        check("ign busy c2", 32'(busy), 32'd1);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("ign done", 32'(done), 32'd1);
        check("ign Diff", 32'(Diff), 32'd3);
        check("ign Bout", 32'(Bout), 32'd0);
        @(negedge clk);
        check("ign no restart", 32'(busy), 32'd0);

        // Back-to-back with start held high: done at cycles 5 and 10.
        @(negedge clk);
        in1 = 4'd9; in2 = 4'd3; Bin = 1'b0; start = 1'b1;
        @(negedge clk);
        in1 = 4'd3; in2 = 4'd9;
        for (int c = 1; c <= 10; c++) begin
            if (c == 5 || c == 10) begin
                check("b2b done", 32'(done), 32'd1);
                check("b2b busy off", 32'(busy), 32'd0);
                check("b2b Diff", 32'(Diff), (c == 5) ? 32'd6 : 32'hA);
                check("b2b Bout", 32'(Bout), (c == 5) ? 32'd0 : 32'd1);
            end else begin
                check("b2b busy", 32'(busy), 32'd1);
                check("b2b done low", 32'(done), 32'd0);
            end
            if (c == 6) begin
                check("b2b held Diff", 32'(Diff), 32'd6);
                start = 1'b0;
            end
            @(negedge clk);
        end
        check("b2b to idle", 32'(busy), 32'd0);

        // Reset in cycle 2 of RUN aborts the operation.
        in1 = 4'd5; in2 = 4'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort Diff", 32'(Diff), 32'd0);
        check("abort Bout", 32'(Bout), 32'd0);
        check("abort Vout", 32'(Vout), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check("abort no done", 32'(done), 32'd0);
            @(negedge clk);
        end
        do_op(4'd6, 4'd1, 1'b0, 4'd5, 1'b0, 1'b0, "post-reset");

        // Exhaustive against an arithmetic reference.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int bi = 0; bi < 2; bi++) begin
                    ud = a - b - bi;
                    md = ud[3:0];
                    mb = (ud < 0);
                    sd = ((a > 7) ? a - 16 : a) - ((b > 7) ? b - 16 : b) - bi;
                    mv = (sd < -8) || (sd > 7);
                    do_op(4'(a), 4'(b), 1'(bi), md, mb, mv, "exh");
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
